// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches over req/gnt/rvalid, buffers words and drives IF/ID.
// Optional macro IF_FETCH_BYPASS_EN lets a returning word skip an empty buffer straight into IF/ID.
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        pc_invalid_o
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W:0]   DEPTH_CAP = (CNT_W + 1)'(FIFO_DEPTH);

    logic [31:0]      fetchPc_q, fetchPc_d, respPc_q, respPc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d, drop_q, drop_d;
    logic [CNT_W-1:0] fifoCount_q, fifoCount_d;
    logic             halted_q, halted_d, haltPending_q, haltPending_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d;
    logic [31:0]      fifoPc_q   [FIFO_DEPTH];
    logic [31:0]      fifoInst_q [FIFO_DEPTH];
    logic             fifoInv_q  [FIFO_DEPTH];
    logic             ifValid_q, ifValid_d, ifInv_q, ifInv_d;
    logic [31:0]      ifPc_q, ifPc_d, ifInst_q, ifInst_d;
    logic             handshake, dropWord, rspWord, haltPush, bypass, push, pop;
    logic [31:0]      pushInst;

    // The cap counts in-flight requests as well as buffered words, so the buffer can never overflow.
    assign imem_req_o  = rst && !halted_q && !branch_flag_i &&
                         (({1'b0, outstanding_q} + {1'b0, fifoCount_q}) < DEPTH_CAP);
    assign imem_addr_o = {fetchPc_q[31:2], 2'b00};

    assign handshake = imem_req_o && imem_gnt_i;
    assign dropWord  = imem_rvalid_i && (drop_q != '0);
    assign rspWord   = imem_rvalid_i && (drop_q == '0) && !branch_flag_i;
    assign haltPush  = haltPending_q && (drop_q == '0) && !branch_flag_i;

`ifdef IF_FETCH_BYPASS_EN
    assign bypass = rspWord && !stall_i && (fifoCount_q == '0);
`else
    assign bypass = 1'b0;
`endif

    assign push     = haltPush || (rspWord && !bypass);
    assign pop      = !branch_flag_i && !stall_i && (fifoCount_q != '0);
    assign pushInst = haltPush ? NOP_INST : imem_rdata_i;

    always_comb begin
        fetchPc_d     = fetchPc_q;
        respPc_d      = respPc_q;
        drop_d        = drop_q;
        halted_d      = halted_q;
        haltPending_d = haltPending_q;
        outstanding_d = outstanding_q + CNT_W'(handshake) - CNT_W'(imem_rvalid_i);
        if (branch_flag_i) begin
            fetchPc_d     = branch_target_i;
            respPc_d      = branch_target_i;
            drop_d        = outstanding_q - CNT_W'(imem_rvalid_i);
            halted_d      = (branch_target_i[1:0] != 2'b00);
            haltPending_d = (branch_target_i[1:0] != 2'b00);
        end else begin
            if (handshake) fetchPc_d = fetchPc_q + 32'd4;
            if (dropWord)  drop_d = drop_q - CNT_W'(1);
            if (rspWord)   respPc_d = respPc_q + 32'd4;
            if (haltPush)  haltPending_d = 1'b0;
        end
    end

    always_comb begin
        rdPtr_d     = rdPtr_q;
        wrPtr_d     = wrPtr_q;
        fifoCount_d = fifoCount_q;
        if (branch_flag_i) begin
            rdPtr_d     = '0;
            wrPtr_d     = '0;
            fifoCount_d = '0;
        end else begin
            if (push) wrPtr_d = (wrPtr_q == LAST_PTR) ? '0 : wrPtr_q + PTR_W'(1);
            if (pop)  rdPtr_d = (rdPtr_q == LAST_PTR) ? '0 : rdPtr_q + PTR_W'(1);
            fifoCount_d = fifoCount_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // A redirect always bubbles IF/ID, even when ctrl is stalling.
    always_comb begin
        ifValid_d = ifValid_q;
        ifPc_d    = ifPc_q;
        ifInst_d  = ifInst_q;
        ifInv_d   = ifInv_q;
        if (branch_flag_i || (!stall_i && !pop && !bypass)) begin
            ifValid_d = 1'b0;
            ifInst_d  = NOP_INST;
            ifInv_d   = 1'b0;
        end else if (pop) begin
            ifValid_d = 1'b1;
            ifPc_d    = fifoPc_q[rdPtr_q];
            ifInst_d  = fifoInst_q[rdPtr_q];
            ifInv_d   = fifoInv_q[rdPtr_q];
        end else if (bypass) begin
            ifValid_d = 1'b1;
            ifPc_d    = respPc_q;
            ifInst_d  = imem_rdata_i;
            ifInv_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifoPc_q[wrPtr_q]   <= respPc_q;
            fifoInst_q[wrPtr_q] <= pushInst;
            fifoInv_q[wrPtr_q]  <= haltPush;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetchPc_q     <= RESET_PC;
            respPc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            fifoCount_q   <= '0;
            halted_q      <= 1'b0;
            haltPending_q <= 1'b0;
            rdPtr_q       <= '0;
            wrPtr_q       <= '0;
            ifValid_q     <= 1'b0;
            ifPc_q        <= 32'd0;
            ifInst_q      <= NOP_INST;
            ifInv_q       <= 1'b0;
        end else begin
            fetchPc_q     <= fetchPc_d;
            respPc_q      <= respPc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            fifoCount_q   <= fifoCount_d;
            halted_q      <= halted_d;
            haltPending_q <= haltPending_d;
            rdPtr_q       <= rdPtr_d;
            wrPtr_q       <= wrPtr_d;
            ifValid_q     <= ifValid_d;
            ifPc_q        <= ifPc_d;
            ifInst_q      <= ifInst_d;
            ifInv_q       <= ifInv_d;
        end
    end

    assign valid_o      = ifValid_q;
    assign pc_o         = ifPc_q;
    assign inst_o       = ifInst_q;
    assign pc_invalid_o = ifInv_q;
endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: an in-order memory responder feeds a scoreboard of expected IF/ID entries.
// A second instance with RESET_PC=FFFF_FFF8 shares the handshake to show PC wrap from reset.
module tb_if_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IF_FETCH_BYPASS_EN
    localparam int FIRST_LAT = 2;
`else
    localparam int FIRST_LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i, branch_flag_i, imem_gnt_i, imem_rvalid_i;
    logic [31:0] branch_target_i, imem_rdata_i;
    logic        imem_req_o, valid_o, pc_invalid_o;
    logic [31:0] imem_addr_o, pc_o, inst_o;
    logic        d2Req, d2Valid, d2Inv;
    logic [31:0] d2Addr, d2Pc, d2Inst;

    always #5 clk = ~clk;

    if_stage u_dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .branch_flag_i(branch_flag_i),
        .branch_target_i(branch_target_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .valid_o(valid_o), .pc_o(pc_o), .inst_o(inst_o), .pc_invalid_o(pc_invalid_o)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFF8)) u_dutWrap (
        .clk(clk), .rst(rst), .stall_i(stall_i), .branch_flag_i(branch_flag_i),
        .branch_target_i(branch_target_i), .imem_req_o(d2Req), .imem_addr_o(d2Addr),
        .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .valid_o(d2Valid), .pc_o(d2Pc), .inst_o(d2Inst), .pc_invalid_o(d2Inv)
    );

    typedef struct { int due; logic [31:0] addr; bit stale; } pend_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; logic inv; } exp_t;

    pend_t       pendQ[$];
    exp_t        sbQ[$];
    int          checks, failures, cycle, rspDelay, firstGrant, firstValid, popped;
    logic [31:0] expAddr, targetV, lastPc, lastInst;
    logic        lastValid;
    bit          stallV, branchV, gntEn, haltedExp, prevStall, prevBranch, phase1;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check IF/ID, drive inputs, model the memory and the expected stream.
    task automatic applyStimulus();
        pend_t p;
        exp_t  e;
        bit    rv;
        if (prevBranch) begin
            checkOutput("flush_valid", 32'(valid_o), 32'd0);
            checkOutput("flush_inst", inst_o, NOP);
        end else if (prevStall) begin
            checkOutput("hold_valid", 32'(valid_o), 32'(lastValid));
            checkOutput("hold_pc", pc_o, lastPc);
            checkOutput("hold_inst", inst_o, lastInst);
        end else if (valid_o === 1'b1) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpected_valid", 32'(valid_o), 32'd0);
            end else begin
                e = sbQ.pop_front();
                popped++;
                if (firstValid < 0) firstValid = cycle;
                checkOutput("sb_pc", pc_o, e.pc);
                checkOutput("sb_inst", inst_o, e.inst);
                checkOutput("sb_invalid", 32'(pc_invalid_o), 32'(e.inv));
                if (phase1 && popped <= 3) begin
                    checkOutput("wrap_valid", 32'(d2Valid), 32'd1);
                    checkOutput("wrap_pc", d2Pc, 32'hFFFF_FFF8 + 32'(4 * (popped - 1)));
                    checkOutput("wrap_inst", d2Inst, e.inst);
                end
            end
        end else begin
            checkOutput("bubble_inst", inst_o, NOP);
        end
        lastValid = valid_o;
        lastPc    = pc_o;
        lastInst  = inst_o;

        rv = (pendQ.size() != 0) && (pendQ[0].due <= cycle);
        stall_i         = stallV;
        branch_flag_i   = branchV;
        branch_target_i = targetV;
        imem_gnt_i      = gntEn;
        imem_rvalid_i   = rv;
        imem_rdata_i    = rv ? memWord(pendQ[0].addr) : 32'hDEAD_BEEF;
        #1;
        if (branchV)        checkOutput("req_on_redirect", 32'(imem_req_o), 32'd0);
        else if (haltedExp) checkOutput("req_while_halted", 32'(imem_req_o), 32'd0);
        if (imem_req_o === 1'b1 && gntEn) begin
            checkOutput("fetch_addr", imem_addr_o, expAddr);
            pendQ.push_back('{cycle + rspDelay, expAddr, 1'b0});
            if (firstGrant < 0) firstGrant = cycle;
            expAddr += 32'd4;
            checkOutput("in_flight_cap", 32'(pendQ.size() > 2), 32'd0);
        end
        if (rv) begin
            p = pendQ.pop_front();
            if (!p.stale && !branchV) sbQ.push_back('{p.addr, memWord(p.addr), 1'b0});
        end
        if (branchV) begin
            foreach (pendQ[i]) pendQ[i].stale = 1'b1;
            sbQ.delete();
            expAddr   = targetV;
            haltedExp = (targetV[1:0] != 2'b00);
            if (haltedExp) sbQ.push_back('{targetV, NOP, 1'b1});
        end
        prevStall  = stallV;
        prevBranch = branchV;
        branchV    = 1'b0;
        cycle++;
        @(negedge clk);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_req"}, 32'(imem_req_o), 32'd0);
        checkOutput({tag, "_addr"}, imem_addr_o, 32'd0);
        checkOutput({tag, "_valid"}, 32'(valid_o), 32'd0);
        checkOutput({tag, "_pc"}, pc_o, 32'd0);
        checkOutput({tag, "_inst"}, inst_o, NOP);
        checkOutput({tag, "_invalid"}, 32'(pc_invalid_o), 32'd0);
        checkOutput({tag, "_wrap_addr"}, d2Addr, 32'hFFFF_FFF8);
    endtask

    initial begin
        checks = 0; failures = 0; cycle = 0; rspDelay = 1; popped = 0;
        firstGrant = -1; firstValid = -1; expAddr = 32'd0; targetV = 32'd0;
        stallV = 1'b0; branchV = 1'b0; gntEn = 1'b1; haltedExp = 1'b0;
        prevStall = 1'b0; prevBranch = 1'b0; phase1 = 1'b1;
        lastValid = 1'b0; lastPc = 32'd0; lastInst = NOP;
        rst = 1'b0; stall_i = 1'b0; branch_flag_i = 1'b0; branch_target_i = 32'd0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetValues("reset");
        rst = 1'b1;
        #1;
        checkOutput("req_after_release", 32'(imem_req_o), 32'd1);

        // Free-running fetch with single-cycle memory.
        repeat (12) applyStimulus();
        checkOutput("first_valid_latency", 32'(firstValid - firstGrant), 32'(FIRST_LAT));
        phase1 = 1'b0;

        stallV = 1'b1;
        repeat (3) applyStimulus();
        stallV = 1'b0;
        repeat (6) applyStimulus();

        // Redirect while two fetches are in flight.
        rspDelay = 4;
        for (int i = 0; i < 20 && pendQ.size() < 2; i++) applyStimulus();
        checkOutput("two_outstanding", 32'(pendQ.size()), 32'd2);
        targetV = 32'h0000_0100; branchV = 1'b1;
        repeat (14) applyStimulus();

        // Misaligned target halts fetching and yields one invalid entry.
        targetV = 32'h0000_0102; branchV = 1'b1;
        repeat (12) applyStimulus();
        checkOutput("halt_entry_seen", 32'(sbQ.size()), 32'd0);

        rspDelay = 1;
        targetV = 32'h0000_0200; branchV = 1'b1;
        repeat (10) applyStimulus();

        targetV = 32'hFFFF_FFF8; branchV = 1'b1;
        repeat (12) applyStimulus();

        // Grant withheld: request must stay up with a stable address.
        gntEn = 1'b0;
        repeat (4) applyStimulus();
        for (int i = 0; i < 5; i++) begin
            checkOutput("req_held", 32'(imem_req_o), 32'd1);
            checkOutput("addr_stable", imem_addr_o, expAddr);
            applyStimulus();
        end
        gntEn = 1'b1; rspDelay = 4;
        repeat (20) applyStimulus();

        // Asynchronous reset in mid-stream.
        #2 rst = 1'b0;
        #1;
        checkResetValues("midreset");
        @(negedge clk);
        @(negedge clk);
        pendQ.delete(); sbQ.delete();
        expAddr = 32'd0; haltedExp = 1'b0; prevStall = 1'b0; prevBranch = 1'b0; rspDelay = 1;
        rst = 1'b1;
        repeat (10) applyStimulus();

        gntEn = 1'b0;
        repeat (8) applyStimulus();
        checkOutput("sb_drained", 32'(sbQ.size()), 32'd0);
        checkOutput("pend_drained", 32'(pendQ.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage: owns the PC, issues word fetches to instruction memory over a req/gnt/rvalid handshake, and buffers returned words in a small FIFO.
- Drives the IF/ID pipeline register (pc_o, inst_o, pc_invalid_o) consumed directly by the decode stage.
- Honours the ctrl-unit stall and EX-stage branch/jump redirects. Flags misaligned target PCs instead of fetching them.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, fetch-buffer entries; also the cap on outstanding requests plus buffered words.
- NOP_INST, 32'h0000_0013, instruction placed in inst_o for a bubble (addi x0,x0,0).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- stall_i  in  1  ctrl stall of IF/ID; 1 = hold register contents
- branch_flag_i  in  1  redirect request from EX (JAL / taken BEQ)
- branch_target_i  in  32  redirect PC
- imem_req_o  out  1  fetch request
- imem_addr_o  out  32  fetch address, word aligned
- imem_gnt_i  in  1  request accepted this cycle
- imem_rvalid_i  in  1  read data valid; responses in order, ≥1 cycle after grant
- imem_rdata_i  in  32  instruction word
- valid_o  out  1  IF/ID holds a real instruction
- pc_o  out  32  PC of the IF/ID instruction
- inst_o  out  32  instruction to ID
- pc_invalid_o  out  1  IF/ID entry represents a misaligned PC

Behaviour:
- Reset (rst low, async):
  - fetch_pc=RESET_PC; FIFO empty; outstanding=0; drop=0; halted=0.
  - imem_req_o=0, imem_addr_o=RESET_PC, valid_o=0, pc_o=0, inst_o=NOP_INST, pc_invalid_o=0.
  - First request is raised in the first cycle after release.
- Request rules:
  - imem_req_o=1 iff !halted && !branch_flag_i && (outstanding+fifo_count)<FIFO_DEPTH.
  - imem_addr_o=fetch_pc.
  - On req&&gnt: fetch_pc+=4 (wraps 32'hFFFF_FFFC→0) and outstanding+1.
  - req may drop without gnt (no hold obligation).
- Response rules:
  - On rvalid: outstanding-1.
  - If drop>0: discard the word and drop-1.
  - Otherwise push {pc, rdata, invalid=0}; the entry PC is tracked by a response-PC counter that advances by 4 per response.
  - Grant and rvalid in the same cycle update the counter by net 0.
- IF/ID register (updates on clock edge):
  - redirect: load bubble (valid_o=0, inst_o=NOP_INST, pc_invalid_o=0); overrides stall_i.
  - else stall_i=1: hold all outputs.
  - else FIFO non-empty: pop the head into pc_o/inst_o/pc_invalid_o, valid_o=1.
  - else: bubble.
- Latency without bypass: rvalid in cycle t → FIFO at end of t → visible on outputs in cycle t+2.
- Redirect (branch_flag_i=1 for one cycle):
  - FIFO cleared; no request that cycle; fetch_pc and response-PC counter set to branch_target_i.
  - drop = outstanding minus any rvalid arriving that same cycle (that word is discarded).
  - If branch_target_i[1:0]≠0: halted=1, no further requests, and a single entry {pc=target, NOP_INST, invalid=1} is pushed once drop reaches 0.
  - Only a new redirect clears halted.
- FIFO full:
  - Cannot overflow, because the request cap counts outstanding requests.
  - Push and pop in the same cycle when full is legal; occupancy is unchanged.
- Redirect while stalled: flush still takes effect; ctrl must not assert both unless intending the flush.

Optional Feature:
- Macro IF_FETCH_BYPASS_EN.
- Defined: when the FIFO is empty, drop=0, stall_i=0 and there is no redirect, an arriving rvalid word loads the IF/ID register directly on the same edge. Visible in cycle t+1, and the FIFO is not written.
- Undefined: every word passes through the FIFO; latency t+2.
- Functionally identical instruction stream either way.

Test Plan:
- Reset release with gnt=1 always and rvalid 1 cycle after grant → addresses 0,4,8,… issued back-to-back; valid_o first high with pc_o=0, inst_o=first word, 3 cycles after first grant (2 with bypass).
- stall_i high 3 cycles mid-stream → pc_o/inst_o hold; at most FIFO_DEPTH requests in flight; no word lost or duplicated after release.
- Redirect to 32'h100 with 2 requests outstanding → both responses discarded; next valid_o shows pc_o=32'h100.
- Redirect to 32'h102 → no further imem_req_o; one entry with pc_o=32'h102, pc_invalid_o=1, inst_o=NOP_INST; a later redirect to 32'h200 resumes fetching.
- RESET_PC=32'hFFFF_FFF8 → pc_o sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- imem_gnt_i low 5 cycles, then rvalid delayed 4 cycles → imem_req_o stays high and the address is stable; outputs show bubbles; order preserved; asserting rst mid-stream returns all outputs to their reset values immediately.
